// File: rtl/multi_pad_reader.sv
// -----------------------------------------------------------------------------
// multi_pad_reader
//
// Polls NUM_PADS shift-register game pads in parallel. All pads share one latch
// line and one shift-pulse line; each pad returns its bits on its own serial
// data input. Once every POLL_PERIOD clocks a frame is run:
//   LATCH : latch held high for LATCH_CYCLES
//   SHIFT : NUM_BUTTONS bit slots of BIT_CYCLES each. The pulse is high for the
//           last PULSE_HIGH cycles of every slot. Data is sampled on the last
//           low cycle before the pulse rises.
//   DONE  : one cycle in which the captured words are published.
// The published words are active-high (pressed = 1) and change only when the
// buttons_valid strobe fires, so downstream logic sees one stable snapshot per
// frame.
//
// Ports
//   clk           system clock (only clock used)
//   n_rst         asynchronous active-low reset
//   enable        allows new frames to start; a running frame always completes
//   data          per-pad serial input, active-low, data[p] belongs to pad p
//   latch         shared pad latch (registered)
//   pulse         shared pad shift clock (registered)
//   buttons       pressed flags, pad p at [p*NUM_BUTTONS +: NUM_BUTTONS]
//   buttons_valid one-cycle strobe when buttons is updated
//   changed       per-pad "word differs from the previous one", only with strobe
//   busy          high while in LATCH or SHIFT
//   present       (only with PAD_PRESENT_EN) per-pad presence flag
//
// Optional build macro
//   PAD_PRESENT_EN : adds the present output. A pad whose line reads "pressed"
//                    for every bit is treated as absent (data stuck low); its
//                    word is published as all zeros.
// -----------------------------------------------------------------------------
module multi_pad_reader #(
  parameter int NUM_PADS     = 2,
  parameter int NUM_BUTTONS  = 8,
  parameter int POLL_PERIOD  = 833333,
  parameter int LATCH_CYCLES = 600,
  parameter int BIT_CYCLES   = 600,
  parameter int PULSE_HIGH   = 300
) (
  input  logic                            clk,
  input  logic                            n_rst,
  input  logic                            enable,
  input  logic [NUM_PADS-1:0]             data,
  output logic                            latch,
  output logic                            pulse,
  output logic [NUM_PADS*NUM_BUTTONS-1:0] buttons,
  output logic                            buttons_valid,
  output logic [NUM_PADS-1:0]             changed,
  output logic                            busy
`ifdef PAD_PRESENT_EN
  ,
  output logic [NUM_PADS-1:0]             present
`endif
);

  // ---------------------------------------------------------------------------
  // Derived sizes and typed constants
  // ---------------------------------------------------------------------------
  localparam int WORDS_W = NUM_PADS * NUM_BUTTONS;
  localparam int PW      = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int CNT_MAX = (LATCH_CYCLES > BIT_CYCLES) ? LATCH_CYCLES : BIT_CYCLES;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int SW      = (NUM_BUTTONS > 1) ? $clog2(NUM_BUTTONS) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [CW-1:0] LATCH_LAST  = CW'(LATCH_CYCLES - 1);
  localparam logic [CW-1:0] BIT_LAST    = CW'(BIT_CYCLES - 1);
  localparam logic [CW-1:0] PULSE_START = CW'(BIT_CYCLES - PULSE_HIGH);
  localparam logic [CW-1:0] SAMPLE_PT   = CW'(BIT_CYCLES - PULSE_HIGH - 1);
  localparam logic [SW-1:0] SLOT_LAST   = SW'(NUM_BUTTONS - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LATCH = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t               state_q, state_d;
  logic [PW-1:0]        period_q, period_d;
  logic [CW-1:0]        cnt_q, cnt_d;       // latch width counter / slot counter
  logic [SW-1:0]        slot_q, slot_d;     // bit slot index within SHIFT
  logic                 latch_q, latch_d;
  logic                 pulse_q, pulse_d;
  logic [WORDS_W-1:0]   shadow_q, shadow_d; // capture area filled during SHIFT
  logic [WORDS_W-1:0]   buttons_q, buttons_d;
  logic                 valid_q;
  logic [NUM_PADS-1:0]  changed_q, changed_d;

  logic                 period_last;
  logic                 sample_en;
  logic                 done_en;
  logic [NUM_BUTTONS-1:0] slot_onehot;

  // ---------------------------------------------------------------------------
  // Free-running frame timer; independent of enable and of the FSM so the
  // frame rate stays fixed whether or not frames are actually being run.
  // ---------------------------------------------------------------------------
  assign period_last = (period_q == PERIOD_LAST);
  assign period_d    = period_last ? '0 : period_q + 1'b1;

  // ---------------------------------------------------------------------------
  // FSM next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    slot_d  = slot_q;

    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        slot_d = '0;
        if (period_last && enable) begin
          state_d = ST_LATCH;
        end
      end

      ST_LATCH: begin
        if (cnt_q == LATCH_LAST) begin
          state_d = ST_SHIFT;
          cnt_d   = '0;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_SHIFT: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (slot_q == SLOT_LAST) begin
            state_d = ST_DONE;
          end else begin
            slot_d = slot_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        slot_d  = '0;
      end

      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
        slot_d  = '0;
      end
    endcase
  end

  // Bus outputs are registered from the next state so they are glitch-free and
  // line up exactly with the state/counter values of the cycle they appear in.
  always_comb begin
    latch_d = (state_d == ST_LATCH);
    pulse_d = (state_d == ST_SHIFT) && (cnt_d >= PULSE_START);
  end

  // Sample on the last low cycle of the slot: the pad has had the whole low
  // phase to settle after the previous shift.
  assign sample_en   = (state_q == ST_SHIFT) && (cnt_q == SAMPLE_PT);
  assign done_en     = (state_q == ST_DONE);
  assign slot_onehot = {{(NUM_BUTTONS-1){1'b0}}, 1'b1} << slot_q;

  // ---------------------------------------------------------------------------
  // Per-pad capture and publish logic
  // ---------------------------------------------------------------------------
`ifdef PAD_PRESENT_EN
  logic [NUM_PADS-1:0] present_q, present_d;
`endif

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PADS; gi++) begin : g_pad
      logic [NUM_BUTTONS-1:0] cur_word;
      logic [NUM_BUTTONS-1:0] old_word;
      logic [NUM_BUTTONS-1:0] load_word;

      assign cur_word = shadow_q[gi*NUM_BUTTONS +: NUM_BUTTONS];
      assign old_word = buttons_q[gi*NUM_BUTTONS +: NUM_BUTTONS];

      // First slot lands in the LSB; data is inverted to active-high here.
      assign shadow_d[gi*NUM_BUTTONS +: NUM_BUTTONS] =
        sample_en ? ((cur_word & ~slot_onehot) | ({NUM_BUTTONS{~data[gi]}} & slot_onehot))
                  : cur_word;

`ifdef PAD_PRESENT_EN
      // All bits pressed means the line never went high: no pad attached.
      assign present_d[gi] = ~(&cur_word);
      assign load_word     = present_d[gi] ? cur_word : '0;
`else
      assign load_word = cur_word;
`endif

      assign buttons_d[gi*NUM_BUTTONS +: NUM_BUTTONS] = done_en ? load_word : old_word;
      assign changed_d[gi] = done_en && (load_word != old_word);
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= ST_IDLE;
      period_q  <= '0;
      cnt_q     <= '0;
      slot_q    <= '0;
      latch_q   <= 1'b0;
      pulse_q   <= 1'b0;
      shadow_q  <= '0;
      buttons_q <= '0;
      valid_q   <= 1'b0;
      changed_q <= '0;
    end else begin
      state_q   <= state_d;
      period_q  <= period_d;
      cnt_q     <= cnt_d;
      slot_q    <= slot_d;
      latch_q   <= latch_d;
      pulse_q   <= pulse_d;
      shadow_q  <= shadow_d;
      buttons_q <= buttons_d;
      valid_q   <= done_en;
      changed_q <= changed_d;
    end
  end

`ifdef PAD_PRESENT_EN
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      present_q <= '0;
    end else if (done_en) begin
      present_q <= present_d;
    end
  end

  assign present = present_q;
`endif

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign latch         = latch_q;
  assign pulse         = pulse_q;
  assign buttons       = buttons_q;
  assign buttons_valid = valid_q;
  assign changed       = changed_q;
  assign busy          = (state_q == ST_LATCH) || (state_q == ST_SHIFT);

  // A frame is always shorter than the poll period, so the timer must never
  // wrap while a frame is still running.
`ifndef SYNTHESIS
  a_no_wrap_mid_frame : assert property (
    @(posedge clk) disable iff (!n_rst)
    period_last |-> (state_q == ST_IDLE)
  ) else $error("multi_pad_reader: poll period expired while a frame was running");
`endif

endmodule

// File: tb/tb_multi_pad_reader.sv
module tb_multi_pad_reader;

  localparam int NP       = 2;
  localparam int NB       = 8;
  localparam int P        = 200;
  localparam int L        = 12;
  localparam int B        = 10;
  localparam int PH       = 5;
  localparam int DONE_OFF = L + NB * B;   // frame offset of the DONE cycle
  localparam int SAMPLE   = B - PH - 1;   // slot position of the sample point

  logic                clk = 1'b0;
  logic                n_rst;
  logic                enable;
  logic [NP-1:0]       data;
  logic                latch;
  logic                pulse;
  logic [NP*NB-1:0]    buttons;
  logic                buttons_valid;
  logic [NP-1:0]       changed;
  logic                busy;
`ifdef PAD_PRESENT_EN
  logic [NP-1:0]       present;
`endif

  always #5 clk = ~clk;

  multi_pad_reader #(
    .NUM_PADS    (NP),
    .NUM_BUTTONS (NB),
    .POLL_PERIOD (P),
    .LATCH_CYCLES(L),
    .BIT_CYCLES  (B),
    .PULSE_HIGH  (PH)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .enable       (enable),
    .data         (data),
    .latch        (latch),
    .pulse        (pulse),
    .buttons      (buttons),
    .buttons_valid(buttons_valid),
    .changed      (changed),
    .busy         (busy)
`ifdef PAD_PRESENT_EN
    ,
    .present      (present)
`endif
  );

  // Counters
  int vectors    = 0;
  int miscompares = 0;

  // Behavioural model: time t since reset release, f = start cycle of the
  // current/last frame (-1 none). Bus outputs follow from the offset t-f.
  int               t;
  int               f;
  logic [NP*NB-1:0] m_shadow;
  logic [NP*NB-1:0] m_buttons;
  logic             m_valid;
  logic [NP-1:0]    m_changed;
  logic [NP-1:0]    m_present;

  // Stimulus controls
  bit               en_cmd;
  bit               noise;
  logic [NB-1:0]    pat [NP];     // line level presented at each slot's sample point

  // Observations of DUT events, compared against literal expectations
  int               first_latch_t;
  int               latch_cycles;
  int               pulse_rises;
  int               valid_count;
  int               last_valid_t;
  logic [NP-1:0]    last_changed;
  logic             prev_latch;
  logic             prev_pulse;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at t=%0d: got %0h, expected %0h", name, t, act, exp);
    end
  endtask

  task automatic model_reset();
    t             = 0;
    f             = -1;
    m_shadow      = '0;
    m_buttons     = '0;
    m_valid       = 1'b0;
    m_changed     = '0;
    m_present     = '0;
    first_latch_t = -1;
    latch_cycles  = 0;
    pulse_rises   = 0;
    valid_count   = 0;
    last_valid_t  = -1;
    last_changed  = '0;
    prev_latch    = 1'b0;
    prev_pulse    = 1'b0;
  endtask

  // One clock cycle: compare, drive, advance the model.
  task automatic step();
    int o;
    bit act_f, in_shift;
    int slot, pos;
    logic e_latch, e_pulse, e_busy;
    logic [NP*NB-1:0] nb;
    logic [NP-1:0] nch, npr;
    logic [NB-1:0] word;

    @(negedge clk);
    o        = t - f;
    act_f    = (f >= 0) && (o >= 0) && (o <= DONE_OFF);
    in_shift = act_f && (o >= L) && (o < DONE_OFF);
    slot     = in_shift ? (o - L) / B : 0;
    pos      = in_shift ? (o - L) % B : 0;
    e_latch  = act_f && (o < L);
    e_busy   = act_f && (o < DONE_OFF);
    e_pulse  = in_shift && (pos >= B - PH);

    chk("latch", 32'(latch), 32'(e_latch));
    chk("pulse", 32'(pulse), 32'(e_pulse));
    chk("busy", 32'(busy), 32'(e_busy));
    chk("buttons", 32'(buttons), 32'(m_buttons));
    chk("buttons_valid", 32'(buttons_valid), 32'(m_valid));
    chk("changed", 32'(changed), 32'(m_changed));
`ifdef PAD_PRESENT_EN
    chk("present", 32'(present), 32'(m_present));
`endif

    if (latch) latch_cycles++;
    if (latch && !prev_latch && first_latch_t < 0) first_latch_t = t;
    if (pulse && !prev_pulse) pulse_rises++;
    if (buttons_valid) begin
      valid_count++;
      last_valid_t = t;
      last_changed = changed;
    end
    prev_latch = latch;
    prev_pulse = pulse;

    enable = en_cmd;
    for (int p = 0; p < NP; p++) begin
      if (in_shift && pos == SAMPLE) data[p] = pat[p][slot];
      else                           data[p] = noise ? 1'($urandom) : 1'b1;
    end

    if (in_shift && pos == SAMPLE) begin
      for (int p = 0; p < NP; p++) m_shadow[p*NB + slot] = ~data[p];
    end

    if (act_f && o == DONE_OFF) begin
      npr = '1;
      for (int p = 0; p < NP; p++) begin
        word = m_shadow[p*NB +: NB];
`ifdef PAD_PRESENT_EN
        npr[p] = (word != {NB{1'b1}});
        if (!npr[p]) word = '0;
`endif
        nch[p] = (word != m_buttons[p*NB +: NB]);
        nb[p*NB +: NB] = word;
      end
      m_buttons = nb;
      m_changed = nch;
      m_valid   = 1'b1;
      m_present = npr;
    end else begin
      m_valid   = 1'b0;
      m_changed = '0;
    end

    if ((t % P) == P - 1 && en_cmd && !act_f) f = t + 1;
    t++;
  endtask

  // Step until the model reaches frame offset 'target'; bounded.
  task automatic wait_off(input int target, input int budget);
    for (int i = 0; i < budget; i++) begin
      step();
      if (f >= 0 && t - f == target) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL wait_off target=%0d: not reached within %0d cycles", target, budget);
  endtask

  task automatic run_frame();
    wait_off(DONE_OFF + 2, 2 * P + 10);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    n_rst  = 1'b0;
    enable = 1'b1;
    data   = '1;
    en_cmd = 1'b1;
    noise  = 1'b0;
    for (int p = 0; p < NP; p++) pat[p] = '1;
    model_reset();

    // Reset values
    #12;
    chk("rst_latch", 32'(latch), 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_buttons", 32'(buttons), 32'd0);
    chk("rst_valid", 32'(buttons_valid), 32'd0);
    chk("rst_changed", 32'(changed), 32'd0);
    @(posedge clk);
    #1 n_rst = 1'b1;
    model_reset();

    // Frame 1: idle pads
    wait_off(DONE_OFF + 2, P + DONE_OFF + 10);
    chk("first_latch_cycle", 32'(first_latch_t), 32'd200);
    chk("latch_width", 32'(latch_cycles), 32'd12);
    chk("pulse_count", 32'(pulse_rises), 32'd8);
    chk("strobe_count", 32'(valid_count), 32'd1);
    chk("strobe_cycle", 32'(last_valid_t), 32'd293);
    chk("idle_buttons", 32'(buttons), 32'd0);
    chk("idle_changed", 32'(last_changed), 32'd0);

    // Frame 2: pad0 line 0,1,1,1,1,1,1,0 -> 8'h81; pad1 idle
    pat[0] = 8'h7E;
    pat[1] = 8'hFF;
    noise  = 1'b1;
    valid_count = 0;
    run_frame();
    chk("pat_buttons", 32'(buttons), 32'h0081);
    chk("pat_changed", 32'(last_changed), 32'h1);
    chk("pat_strobe", 32'(valid_count), 32'd1);

    // Frame 3: same pattern, no change
    valid_count = 0;
    run_frame();
    chk("same_buttons", 32'(buttons), 32'h0081);
    chk("same_changed", 32'(last_changed), 32'h0);
    chk("same_strobe", 32'(valid_count), 32'd1);

    // Random frames
    for (int i = 0; i < 5; i++) begin
      for (int p = 0; p < NP; p++) pat[p] = NB'($urandom);
      run_frame();
    end

    // Enable low across a wrap: no frame
    en_cmd = 1'b0;
    valid_count = 0;
    latch_cycles = 0;
    repeat (P) step();
    chk("disabled_strobes", 32'(valid_count), 32'd0);
    chk("disabled_latch", 32'(latch_cycles), 32'd0);

    // Drop enable mid-SHIFT: frame completes, next one suppressed
    en_cmd = 1'b1;
    wait_off(L + 30, 2 * P + 10);
    en_cmd = 1'b0;
    valid_count = 0;
    wait_off(DONE_OFF + 2, P);
    chk("midshift_strobe", 32'(valid_count), 32'd1);
    valid_count = 0;
    latch_cycles = 0;
    repeat (P) step();
    chk("suppressed_strobes", 32'(valid_count), 32'd0);
    chk("suppressed_latch", 32'(latch_cycles), 32'd0);

    // Known nonzero frame, then reset during slot 4
    en_cmd = 1'b1;
    pat[0] = 8'h5A;
    pat[1] = 8'h3C;
    run_frame();
    chk("fixed_buttons", 32'(buttons), 32'hC3A5);
    wait_off(L + 4 * B + 7, 2 * P + 10);
    @(posedge clk);
    #2;
    chk("pre_rst_pulse", 32'(pulse), 32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    n_rst = 1'b0;
    #1;
    chk("async_latch", 32'(latch), 32'd0);
    chk("async_pulse", 32'(pulse), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_buttons", 32'(buttons), 32'd0);
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1'b1;
    model_reset();
    wait_off(DONE_OFF + 2, P + DONE_OFF + 10);
    chk("post_rst_latch_cycle", 32'(first_latch_t), 32'd200);

`ifdef PAD_PRESENT_EN
    pat[0] = 8'h0F;
    pat[1] = 8'h00;
    run_frame();
    chk("absent_present", 32'(present), 32'h1);
    chk("absent_buttons_hi", 32'(buttons[15:8]), 32'h0);
    pat[1] = 8'hFF;
    run_frame();
    chk("restored_present", 32'(present), 32'h3);
`endif

    // A few more random frames after reset
    for (int i = 0; i < 3; i++) begin
      for (int p = 0; p < NP; p++) pat[p] = NB'($urandom);
      run_frame();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multi_pad_reader.md
Name: multi_pad_reader

Overview:
- Parametrised successor to the single-pad custom controller interface. Polls NUM_PADS shift-register game pads in parallel over a shared latch/pulse bus, with a per-pad serial data input.
- Fully synchronous to clk: no derived clocks and no clocking on data-derived edges.
- Presents debounced-by-frame, active-high button words with a frame-valid strobe and per-pad change flags to downstream game logic.

Parameters:
- NUM_PADS, 2, number of pads and data inputs (1..4).
- NUM_BUTTONS, 8, bits shifted per pad per frame (8..16).
- POLL_PERIOD, 833333, clk cycles between frame starts. Must be > LATCH_CYCLES + NUM_BUTTONS*BIT_CYCLES + 2.
- LATCH_CYCLES, 600, latch high width in cycles.
- BIT_CYCLES, 600, length of one bit slot in cycles.
- PULSE_HIGH, 300, pulse high width at the end of each slot. Must satisfy 1 <= PULSE_HIGH < BIT_CYCLES.

Ports:
- clk  in  1  system clock.
- n_rst  in  1  asynchronous active-low reset.
- enable  in  1  permits new frames to start.
- data  in  NUM_PADS  serial pad outputs, active-low (0 = pressed); data[p] belongs to pad p.
- latch  out  1  shared pad latch.
- pulse  out  1  shared pad shift clock.
- buttons  out  NUM_PADS*NUM_BUTTONS  active-high pressed; pad p occupies bits [p*NUM_BUTTONS +: NUM_BUTTONS].
- buttons_valid  out  1  one-cycle strobe when buttons update.
- changed  out  NUM_PADS  changed[p]=1 with the strobe if pad p's word differs from its previous value.
- busy  out  1  high while a frame is in progress (LATCH or SHIFT).

Behaviour:
- Reset: one clock, asynchronous active-low reset n_rst. All outputs are 0, FSM is IDLE, all counters are 0, shadow registers are 0.
- Period counter:
  - Free-running 0..POLL_PERIOD-1 and wraps to 0.
  - Width is $clog2(POLL_PERIOD).
  - Runs regardless of enable or state.
- FSM states: IDLE, LATCH, SHIFT, DONE.
- IDLE -> LATCH:
  - Taken on the cycle the period counter equals POLL_PERIOD-1, if enable=1.
  - latch is registered, so it rises on the following edge.
  - The first latch is therefore high from cycle POLL_PERIOD after reset release.
- LATCH:
  - latch=1 for exactly LATCH_CYCLES cycles, pulse=0.
  - Then go to SHIFT with slot index 0 and slot counter 0.
- SHIFT:
  - latch=0.
  - Slot counter runs 0..BIT_CYCLES-1.
  - pulse=1 when slot counter >= BIT_CYCLES-PULSE_HIGH, else 0.
  - Sample point is slot counter == BIT_CYCLES-PULSE_HIGH-1, the last low cycle.
  - At the sample point, shadow[p][k] <= ~data[p] for every pad p, where k is the slot index. The first bit goes to the LSB.
  - At the end of slot NUM_BUTTONS-1, go to DONE. Pulses are emitted in all slots, including the last.
- DONE (1 cycle):
  - buttons <= shadow.
  - changed[p] <= (shadow[p] != buttons[p]).
  - buttons_valid <= 1.
  - Return to IDLE.
  - buttons_valid and changed are registered one-cycle strobes; changed is 0 whenever buttons_valid is 0.
- busy = (state == LATCH or SHIFT).
- enable deasserted mid-frame: the frame completes normally. Only new starts are blocked.
- Period wrap while not IDLE: cannot occur under the POLL_PERIOD constraint. RTL carries an assertion for this.
- Reset mid-frame: latch and pulse drop asynchronously and buttons clear to 0. The next frame starts POLL_PERIOD cycles after release.
- Outputs change only in DONE; buttons are stable between strobes.

Optional Feature:
- Macro: PAD_PRESENT_EN.
- With the macro, an extra output present [NUM_PADS] is added, reset 0.
  - In DONE, present[p] <= ~(&shadow[p]). All bits "pressed" means the data line is stuck low, which marks the pad as absent.
  - When present[p] would be 0, buttons[p] is loaded with 0 instead of shadow[p], and changed[p] compares against 0.
- Without the macro, the port does not exist and buttons always loads shadow.

Test Plan:
Common parameters: NUM_PADS=2, NUM_BUTTONS=8, POLL_PERIOD=200, LATCH_CYCLES=12, BIT_CYCLES=10, PULSE_HIGH=5.
- Reset release, enable=1, pads idle (data=2'b11):
  - latch rises at cycle 200 and stays high for 12 cycles.
  - Then 8 pulses, each 5 high / 5 low-first.
  - buttons_valid is strobed once at cycle 200+12+80+1.
  - buttons=0, changed=0.
- Pad0 serial pattern 0,1,1,1,1,1,1,0 and pad1 all 1, each bit aligned to the sample point:
  - buttons[7:0]=8'h81, buttons[15:8]=0.
  - changed=2'b01 with the strobe.
- Identical pattern on the next frame: buttons unchanged, buttons_valid=1, changed=2'b00.
- enable=0 before the wrap: no latch, no strobe that period. Drop enable mid-SHIFT: the frame completes and the following frame is suppressed.
- n_rst asserted during slot 4:
  - latch, pulse, busy and buttons go to 0 immediately.
  - After release, the next latch rises exactly 200 cycles later.
- PAD_PRESENT_EN defined, pad1 data held 0:
  - present=2'b01, buttons[15:8]=0.
  - Releasing pad1 to 1 gives present=2'b11 on the next frame.
